// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter. The lines are driven only through pull-low enables.
// Optional macro PS2_TX_RETRY_EN: one automatic retry after the first NACK or timeout of a request.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES     = 5000,
  parameter int FIRST_EDGE_TIMEOUT = 750000,
  parameter int EDGE_TIMEOUT       = 100000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Start,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_Error,
  output logic       Tx_Active,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);
  localparam int MAX_A = (FIRST_EDGE_TIMEOUT > EDGE_TIMEOUT) ? FIRST_EDGE_TIMEOUT : EDGE_TIMEOUT;
  localparam int MAX_C = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_DONE, S_FAIL, S_RETRY_WAIT
  } state_t;

  state_t        r_state, w_state_next, w_fail_state;
  logic          r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
  logic [7:0]    r_byte;
  logic          r_parity;
  logic [3:0]    r_edge_n;
  logic [CW-1:0] r_cnt;
  logic          r_dat_drv;
  logic          w_fall, w_edge_timed, w_timeout;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_dat_in;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall       = r_clk_prev & ~r_clk_s2;
  assign w_edge_timed = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

`ifdef PS2_TX_RETRY_EN
  logic r_retry;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_retry <= 1'b0;
    else if (r_state == S_DONE || r_state == S_FAIL)
      r_retry <= 1'b0;
    else if (w_state_next == S_RETRY_WAIT)
      r_retry <= 1'b1;
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ps2_clk_oe   = 1'b0;
    ps2_dat_oe   = 1'b0;
    Tx_Done      = 1'b0;
    Tx_Error     = 1'b0;
`ifdef PS2_TX_RETRY_EN
    w_fail_state = r_retry ? S_FAIL : S_RETRY_WAIT;
`else
    w_fail_state = S_FAIL;
`endif
    // The long first-edge limit applies only until the device produces its first falling edge.
    if (r_state == S_SEND && r_edge_n == 4'd0)
      w_timeout = (r_cnt >= CW'(FIRST_EDGE_TIMEOUT));
    else
      w_timeout = (r_cnt >= CW'(EDGE_TIMEOUT));
    case (r_state)
      S_IDLE: begin
        if (Tx_Start) w_state_next = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (r_cnt == CW'(INHIBIT_CYCLES - 1)) w_state_next = S_REQ;
      end
      S_REQ: begin
        ps2_clk_oe   = 1'b1;
        ps2_dat_oe   = 1'b1;
        w_state_next = S_SEND;
      end
      S_SEND: begin
        ps2_dat_oe = r_dat_drv;
        if (w_fall) begin
          if (r_edge_n == 4'd9) w_state_next = S_ACK;
        end else if (w_timeout) begin
          w_state_next = w_fail_state;
        end
      end
      S_ACK: begin
        if (w_fall)
          w_state_next = r_dat_s2 ? w_fail_state : S_WAIT_IDLE;
        else if (w_timeout)
          w_state_next = w_fail_state;
      end
      S_WAIT_IDLE: begin
        if (r_clk_s2 && r_dat_s2)
          w_state_next = S_DONE;
        else if (w_timeout)
          w_state_next = w_fail_state;
      end
      S_DONE: begin
        Tx_Done      = 1'b1;
        w_state_next = S_IDLE;
      end
      S_FAIL: begin
        Tx_Error     = 1'b1;
        w_state_next = S_IDLE;
      end
      S_RETRY_WAIT: begin
        if (r_cnt == CW'(INHIBIT_CYCLES - 1)) w_state_next = S_INHIBIT;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_byte    <= '0;
      r_parity  <= 1'b0;
      r_edge_n  <= '0;
      r_cnt     <= '0;
      r_dat_drv <= 1'b0;
    end else begin
      if (r_state == S_IDLE && Tx_Start) begin
        r_byte   <= Tx_Data;
        r_parity <= ~^Tx_Data;
      end
      // One counter serves the inhibit hold, the retry wait and all edge timeouts.
      if (r_state != w_state_next || (w_fall && w_edge_timed))
        r_cnt <= '0;
      else if (r_cnt != '1)
        r_cnt <= r_cnt + CW'(1);
      if (r_state == S_REQ) begin
        r_edge_n  <= '0;
        r_dat_drv <= 1'b1;
      end else if (r_state == S_SEND && w_fall) begin
        r_edge_n <= r_edge_n + 4'd1;
        if (r_edge_n < 4'd8)
          r_dat_drv <= ~r_byte[r_edge_n[2:0]];
        else if (r_edge_n == 4'd8)
          r_dat_drv <= ~r_parity;
        else
          r_dat_drv <= 1'b0;
      end
    end
  end

  assign Tx_Busy   = (r_state != S_IDLE);
  assign Tx_Active = Tx_Busy;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with a behavioural PS/2 device on an open-drain line model.
// Scaled timing parameters keep each frame short; PS2_TX_RETRY_EN selects the retry expectations.
module tb_ps2_host_transmitter;
  localparam int INH   = 50;
  localparam int FIRST = 600;
  localparam int EDGE  = 200;
  localparam int HP    = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] Tx_Data = 8'h00;
  logic       Tx_Start = 1'b0;
  logic       Tx_Busy, Tx_Done, Tx_Error, Tx_Active;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_transmitter #(
    .INHIBIT_CYCLES     (INH),
    .FIRST_EDGE_TIMEOUT (FIRST),
    .EDGE_TIMEOUT       (EDGE)
  ) dut (
    .Clk        (clk),
    .Reset_n    (rst_n),
    .Tx_Data    (Tx_Data),
    .Tx_Start   (Tx_Start),
    .Tx_Busy    (Tx_Busy),
    .Tx_Done    (Tx_Done),
    .Tx_Error   (Tx_Error),
    .Tx_Active  (Tx_Active),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] b);
    Tx_Data  = b;
    Tx_Start = 1'b1;
    tick(1);
    Tx_Start = 1'b0;
  endtask

  // Counts inhibit cycles (clock pulled, data free) until the clock is released with the start bit held.
  task automatic wait_request(output int inh, output bit ok);
    inh = 0;
    ok  = 1'b0;
    for (int k = 0; k < 4 * INH + 50; k++) begin
      if (ps2_clk_oe && !ps2_dat_oe) inh++;
      if (!ps2_clk_oe && ps2_dat_oe) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // Ten clock pulses sampling data on each rising edge, then the ACK fall with the line left held low.
  task automatic dev_frame(input bit ack_good, input int inject_at, input int reset_at,
                           output logic [9:0] bits, output bit aborted);
    bits    = '0;
    aborted = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(HP);
      dev_clk_low = 1'b1;
      if (i == inject_at) begin
        Tx_Data  = 8'hAA;
        Tx_Start = 1'b1;
        tick(1);
        Tx_Start = 1'b0;
        check_val("busy_at_inject", Tx_Busy, 1);
        tick(HP - 1);
      end else if (i == reset_at) begin
        tick(HP / 2);
        check_val("pre_reset_dat_oe", ps2_dat_oe, 1);
        #1 rst_n = 1'b0;
        #1;
        check_val("async_rst_clk_oe", ps2_clk_oe, 0);
        check_val("async_rst_dat_oe", ps2_dat_oe, 0);
        aborted     = 1'b1;
        dev_clk_low = 1'b0;
        return;
      end else begin
        tick(HP);
      end
      dev_clk_low = 1'b0;
      bits[i-1]   = ps2_dat_in;
    end
    tick(HP / 2);
    dev_dat_low = ack_good;
    tick(HP / 2);
    dev_clk_low = 1'b1;
  endtask

  // Watches for the result pulses; the device lets go of both lines HP cycles after the ACK fall.
  task automatic wait_result(output int nd, output int ne, output int both, output bit oe_clr);
    nd     = 0;
    ne     = 0;
    both   = 0;
    oe_clr = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (k == HP) begin
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
      end
      if (Tx_Done) nd++;
      if (Tx_Error) begin
        ne++;
        if (ps2_clk_oe || ps2_dat_oe) oe_clr = 1'b0;
      end
      if (Tx_Done && Tx_Error) both++;
      if (!Tx_Busy && (nd + ne) > 0) break;
      tick(1);
    end
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  task automatic run_send(input string name, input logic [7:0] b, input bit exp_par, input int inject_at);
    int          inh, nd, ne, both;
    bit          ok, ab, oe_clr;
    logic [9:0]  bits;
    start_tx(b);
    wait_request(inh, ok);
    check_val({name, "_inhibit_len"}, inh, INH);
    check_val({name, "_req_seen"}, ok, 1);
    dev_frame(1'b1, inject_at, 0, bits, ab);
    check_val({name, "_data"}, bits[7:0], b);
    check_val({name, "_parity"}, bits[8], exp_par);
    check_val({name, "_stop"}, bits[9], 1);
    wait_result(nd, ne, both, oe_clr);
    check_val({name, "_done_cnt"}, nd, 1);
    check_val({name, "_err_cnt"}, ne, 0);
    check_val({name, "_done_err_overlap"}, both, 0);
    check_val({name, "_busy_after"}, Tx_Busy, 0);
    $display("send %s byte=%02h bits=%03h inhibit=%0d done=%0d err=%0d", name, b, bits, inh, nd, ne);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         inh, nd, ne, both, since;
    bit         ok, ab, oe_clr, got_err, prev_clk_oe;
    logic [9:0] bits;

    tick(3);
    check_val("rst_busy", Tx_Busy, 0);
    check_val("rst_active", Tx_Active, 0);
    check_val("rst_done", Tx_Done, 0);
    check_val("rst_error", Tx_Error, 0);
    check_val("rst_clk_oe", ps2_clk_oe, 0);
    check_val("rst_dat_oe", ps2_dat_oe, 0);
    rst_n = 1'b1;
    tick(3);
    check_val("idle_busy", Tx_Busy, 0);

    run_send("f4", 8'hF4, 1'b0, 0);
    run_send("00", 8'h00, 1'b1, 0);
    run_send("ff", 8'hFF, 1'b1, 0);

    // NACK: device leaves data high on the ACK edge.
    start_tx(8'h55);
    wait_request(inh, ok);
    check_val("nack_req_seen", ok, 1);
    dev_frame(1'b0, 0, 0, bits, ab);
    check_val("nack_data", bits[7:0], 8'h55);
    check_val("nack_parity", bits[8], 1);
`ifdef PS2_TX_RETRY_EN
    tick(HP);
    dev_clk_low = 1'b0;
    check_val("retry_busy_held", Tx_Busy, 1);
    wait_request(inh, ok);
    check_val("retry_req_seen", ok, 1);
    dev_frame(1'b1, 0, 0, bits, ab);
    check_val("retry_data", bits[7:0], 8'h55);
    wait_result(nd, ne, both, oe_clr);
    check_val("retry_done_cnt", nd, 1);
    check_val("retry_err_cnt", ne, 0);
`else
    wait_result(nd, ne, both, oe_clr);
    check_val("nack_err_cnt", ne, 1);
    check_val("nack_done_cnt", nd, 0);
    check_val("nack_oe_released", oe_clr, 1);
`endif
    $display("send nack byte=55 done=%0d err=%0d", nd, ne);
    tick(2);

    // Device never clocks: measure from the last clock release to the error pulse.
    start_tx(8'hF4);
    since       = 0;
    got_err     = 1'b0;
    prev_clk_oe = 1'b0;
    oe_clr      = 1'b1;
    for (int k = 0; k < 2 * FIRST + 4 * INH + 500; k++) begin
      if (prev_clk_oe && !ps2_clk_oe) since = 0;
      else since++;
      prev_clk_oe = ps2_clk_oe;
      if (Tx_Error) begin
        got_err = 1'b1;
        if (ps2_clk_oe || ps2_dat_oe) oe_clr = 1'b0;
        break;
      end
      tick(1);
    end
    check_val("timeout_err_seen", got_err, 1);
    check_val("timeout_window", (since >= FIRST - 4) && (since <= FIRST + 4), 1);
    check_val("timeout_oe_released", oe_clr, 1);
    $display("timeout err=%0d cycles_after_release=%0d", got_err, since);
    tick(2);

    // Start strobe with 0xAA during SEND must not disturb the 0xF4 frame.
    run_send("busy_ignore", 8'hF4, 1'b0, 3);

    // Asynchronous reset at device edge 5, then a fresh send.
    start_tx(8'h00);
    wait_request(inh, ok);
    check_val("rstmid_req_seen", ok, 1);
    dev_frame(1'b1, 0, 5, bits, ab);
    check_val("rstmid_aborted", ab, 1);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check_val("rstmid_busy", Tx_Busy, 0);
    check_val("rstmid_clk_oe", ps2_clk_oe, 0);
    check_val("rstmid_dat_oe", ps2_dat_oe, 0);
    $display("reset mid-frame aborted=%0d busy=%0d", ab, Tx_Busy);
    run_send("ff_after_rst", 8'hFF, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device side of the PS/2 link. It sends one command byte per request to the mouse, such as 0xF4 (enable data reporting) or 0xFF (reset). It sits beside ps2_mouse_controller on the shared PS2_KBCLK/PS2_KBDAT open-drain pair. It drives the lines only through pull-low enables; the top level builds the tristate buffers.

Parameters:
INHIBIT_CYCLES, 5000, clock-low hold before the request-to-send (100 us at 50 MHz)
FIRST_EDGE_TIMEOUT, 750000, max cycles from releasing clock to the first device falling edge (15 ms)
EDGE_TIMEOUT, 100000, max cycles between later falling edges and for the final idle wait (2 ms)

Ports:
Clk  in  1  system clock, CLOCK_50 domain
Reset_n  in  1  asynchronous, active-low reset
Tx_Data  in  8  command byte, sampled on an accepted Tx_Start
Tx_Start  in  1  request strobe; honoured only while Tx_Busy=0
Tx_Busy  out  1  high from the cycle after acceptance until Done/Error
Tx_Done  out  1  one-cycle pulse: device acknowledged the byte
Tx_Error  out  1  one-cycle pulse: timeout or NACK
Tx_Active  out  1  equals Tx_Busy; the receiver ignores bits while this is high
ps2_clk_in  in  1  raw PS/2 clock line
ps2_dat_in  in  1  raw PS/2 data line
ps2_clk_oe  out  1  1 = pull the clock line low
ps2_dat_oe  out  1  1 = pull the data line low

Behaviour:
- Interface: one clock, Clk. Reset is Reset_n, asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, counters 0. Both lines are released immediately, including when reset hits mid-frame.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer.
  - fall = (previous synced clk = 1) and (current synced clk = 0).
  - This gives a 3-cycle latency from pin to fall.
- Frame: the byte is latched at acceptance. Parity is odd, computed as ~^Tx_Data.
- State machine:
  - IDLE: on Tx_Start, latch the byte, go to INHIBIT, set Tx_Busy.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: for one cycle, dat_oe=1 (start bit) with clk_oe still 1. Then clk_oe=0 and go to SEND with edge count 0. The first-edge timer starts here.
  - SEND: on each fall, increment the edge count n.
    - n=1..8: drive data bit n-1, LSB first. dat_oe = ~bit.
    - n=9: drive parity.
    - n=10: dat_oe=0 (stop bit), go to ACK.
    - The drive value updates on the cycle after fall and holds until the next fall.
  - ACK: on fall, sample synced data. 0 goes to WAIT_IDLE; 1 is a NACK and goes to FAIL.
  - WAIT_IDLE: go to DONE once synced clk=1 and data=1.
  - DONE: pulse Tx_Done, clear Tx_Busy, return to IDLE.
  - FAIL: release both lines, pulse Tx_Error, clear Tx_Busy, return to IDLE.
- Timeouts:
  - A single cycle counter is cleared on every fall.
  - In SEND before the first fall, exceeding FIRST_EDGE_TIMEOUT goes to FAIL.
  - After the first fall, in SEND, ACK or WAIT_IDLE, exceeding EDGE_TIMEOUT goes to FAIL.
- Tx_Start while busy: ignored, not queued.
- Tx_Done and Tx_Error are never high in the same cycle.
- Tx_Start may be re-asserted in the cycle right after Done/Error and is accepted.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on the first NACK or timeout of a request, release the lines, wait INHIBIT_CYCLES, then restart from INHIBIT with the same latched byte.
  - Tx_Busy stays high throughout.
  - Tx_Error pulses only if the retry also fails.
  - The retry flag clears on DONE, FAIL, or reset.
- Undefined: the first failure goes directly to FAIL.

Test Plan:
- Send 0xF4, with the device model clocking at 12.5 kHz and ACKing:
  - clk_oe held low exactly 5000 cycles.
  - Driven bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Tx_Done pulses once; Tx_Busy low afterwards.
- Send 0x00 and 0xFF: the parity bit observed is 1 in both cases. Each completes with Tx_Done.
- Device leaves data high on the ACK edge:
  - Without macro: Tx_Error pulses and both oe go low.
  - With macro: a second frame is observed, and Tx_Done pulses if the second ACK is good.
- Device never clocks: Tx_Error pulses 750000±4 cycles after REQ releases the clock.
- Tx_Start pulsed during SEND with 0xAA: ignored, and the original 0xF4 bit sequence is unaltered.
- Reset_n asserted at edge 5: both oe drop to 0 asynchronously with no clock edge. After release, the block is in IDLE and a fresh 0xFF send succeeds.
